multi_sample_player: RTL and testbench
======================================

MULTI_SAMPLE_PLAYER -- requirements
Module: multi_sample_player

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent sample voices (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16, sample ROM address width.
REQ-003 SHALL have parameter DIV, default 512, clk cycles per sample period; legal only if DIV >= 2*CHANNELS+2.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset; clock is clk.
REQ-006 SHALL have port trig, input, CHANNELS, per-channel start request, level sampled every clk.
REQ-007 SHALL have port stop, input, CHANNELS, per-channel stop request, level sampled every clk.
REQ-008 SHALL have port loop, input, CHANNELS, per-channel loop enable.
REQ-009 SHALL have port start_addr, input, CHANNELS*ADDR_W, packed per-channel first ROM address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port length, input, CHANNELS*ADDR_W, packed per-channel sample count, same packing as start_addr.
REQ-011 SHALL have port rom_addr, output, ADDR_W, shared sample ROM read address.
REQ-012 SHALL have port rom_data, input, 8, unsigned 8-bit PCM, valid exactly 1 clk after rom_addr.
REQ-013 SHALL have port busy, output, CHANNELS, channel active.
REQ-014 SHALL have port done, output, CHANNELS, 1-clk pulse at non-looping sample end.
REQ-015 SHALL have port audio, output, 16, signed mixed output.
REQ-016 SHALL have port sample_strobe, output, 1, 1-clk pulse when audio updates.

Function
REQ-017 Tick counter SHALL count 0..DIV-1 and wrap; the tick is the cycle where count = 0.
REQ-018 trig/stop pulses of any width SHALL set per-channel pending flags, applied and cleared at the next tick.
REQ-019 At a tick, pending stop SHALL clear busy; pending stop and pending trig together SHALL resolve as stop.
REQ-020 At a tick, pending trig with length != 0 SHALL latch start_addr/length, set ptr = 0 and set busy, restarting any playing sample.
REQ-021 A pending trig with length = 0 SHALL be discarded; busy is unchanged.
REQ-022 Fetch sequence SHALL start at tick+1; the slot for channel i drives rom_addr = start+ptr (mod 2^ADDR_W) at cycle tick+1+2i and captures rom_data at tick+2+2i.
REQ-023 The slot sequence SHALL run for every channel regardless of busy, giving fixed timing; rom_addr SHALL hold its last value outside slots.
REQ-024 A non-busy channel SHALL contribute 0 to the mix.
REQ-025 After a capture on a busy channel with ptr < length-1, ptr SHALL increment by 1.
REQ-026 After the capture at ptr = length-1 with loop = 1, ptr SHALL become 0 and busy SHALL remain set.
REQ-027 After the capture at ptr = length-1 with loop = 0, busy SHALL clear and done[i] SHALL pulse in the capture cycle.
REQ-028 The value captured at the final ptr SHALL still be mixed in the current period.
REQ-029 Each contribution SHALL be (rom_data - 128) as signed 9-bit, left-shifted by 8.
REQ-030 All contributions SHALL be summed at full width (16+clog2(CHANNELS) bits), then saturated to [-32768, 32767].
REQ-031 audio SHALL update and sample_strobe SHALL pulse at cycle tick+2*CHANNELS+2; audio SHALL hold between strobes.

Reset
REQ-032 While reset is high, the following SHALL be 0: tick count, pending flags, busy, ptr, done, audio, rom_addr and sample_strobe.
REQ-033 Reset mid-fetch SHALL abort the sequence; after release no strobe SHALL occur before the first full period.

Structure
REQ-034 Package multi_sample_player_pkg SHALL hold the mix-width constant, the saturation limits and a saturate function.
REQ-035 Per-channel state SHALL live in one sub-module, sample_voice, containing pending flags, ptr, busy, the latched start/length and the done pulse; it is instantiated CHANNELS times.
REQ-036 The top level SHALL hold the tick counter, slot sequencer, rom_addr mux and mixer.

Verification (CHANNELS = 4, DIV = 16, ROM[a] = a[7:0] unless stated)
REQ-037 Single shot: ch0 trig with start 0x0100, length 3, loop 0 -> rom_addr 0x0100/0x0101/0x0102 in three successive periods; done[0] pulses once; busy[0] falls; audio stays 0 thereafter.
REQ-038 Loop: ch1 with length 2, loop 1 -> addresses alternate start, start+1 indefinitely; no done pulse.
REQ-039 Saturation: all 4 channels read 0xFF -> audio = 32767; all read 0x00 -> audio = -32768; ch0 0xFF with ch1 0x00 -> audio = -256.
REQ-040 Priority: trig and stop on ch2 in the same cycle -> busy[2] stays 0; trig with length 0 -> ignored.
REQ-041 Retrigger: ch3 at ptr 5 retriggered -> next fetch at start+0; start_addr changed after the tick is not used until the next trig.
REQ-042 Reset: assert reset at tick+3 -> all outputs 0; first strobe occurs at 2*CHANNELS+2 + 16 cycles after release.

Source files
------------

// File: rtl/multi_sample_player_pkg.sv
// rtl/multi_sample_player_pkg.sv - shared mix width, sample format and saturation helper
package multi_sample_player_pkg;

    localparam int MAX_CHANNELS = 8;
    // Wide enough for the largest legal voice count, so any CHANNELS sums without overflow
    localparam int MIX_W        = 16 + $clog2(MAX_CHANNELS);
    localparam int SAMPLE_W     = 9;
    localparam logic [SAMPLE_W-1:0] PCM_BIAS = SAMPLE_W'(128);

    localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'(32767);
    localparam logic signed [MIX_W-1:0] SAT_MIN = MIX_W'(-32768);

    function automatic logic signed [15:0] saturate(input logic signed [MIX_W-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/multi_sample_player_voice.sv
// rtl/multi_sample_player_voice.sv - per-channel request latching, playback pointer and captured sample
module sample_voice
    import multi_sample_player_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trig,
    input  logic                       stop,
    input  logic                       loop,
    input  logic [ADDR_W-1:0]          start_in,
    input  logic [ADDR_W-1:0]          length_in,
    input  logic                       tick,
    input  logic                       capture,
    input  logic [7:0]                 rom_data,
    output logic [ADDR_W-1:0]          fetch_addr,
    output logic                       busy,
    output logic                       done,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic                       pend_trig, pend_trig_n;
    logic                       pend_stop, pend_stop_n;
    logic [ADDR_W-1:0]          ptr, ptr_n;
    logic [ADDR_W-1:0]          start_l, start_n;
    logic [ADDR_W-1:0]          len_l, len_n;
    logic                       busy_n, done_n;
    logic signed [SAMPLE_W-1:0] sample_n;

    always_comb begin
        pend_trig_n = pend_trig | trig;
        pend_stop_n = pend_stop | stop;
        ptr_n       = ptr;
        start_n     = start_l;
        len_n       = len_l;
        busy_n      = busy;
        done_n      = 1'b0;
        sample_n    = sample;
        if (tick) begin
            pend_trig_n = 1'b0;
            pend_stop_n = 1'b0;
            if (pend_stop | stop) begin
                busy_n = 1'b0;
                ptr_n  = '0;
            end else if ((pend_trig | trig) && length_in != '0) begin
                start_n = start_in;
                len_n   = length_in;
                ptr_n   = '0;
                busy_n  = 1'b1;
            end
        end else if (capture) begin
            if (busy) begin
                sample_n = $signed({1'b0, rom_data} - PCM_BIAS);
                if (ptr == len_l - ADDR_W'(1)) begin
                    ptr_n = '0;
                    if (!loop) begin
                        busy_n = 1'b0;
                        done_n = 1'b0 | 1'b1;
                    end
                end else begin
                    ptr_n = ptr + ADDR_W'(1);
                end
            end else begin
                sample_n = '0;
            end
        end
    end

    // Channel 0 is fetched on the tick edge itself, so the address comes from post-tick state
    assign fetch_addr = start_n + ptr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_trig <= 1'b0;
            pend_stop <= 1'b0;
            ptr       <= '0;
            start_l   <= '0;
            len_l     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sample    <= '0;
        end else begin
            pend_trig <= pend_trig_n;
            pend_stop <= pend_stop_n;
            ptr       <= ptr_n;
            start_l   <= start_n;
            len_l     <= len_n;
            busy      <= busy_n;
            done      <= done_n;
            sample    <= sample_n;
        end
    end

endmodule

// File: rtl/multi_sample_player.sv
// rtl/multi_sample_player.sv - tick counter, shared-ROM slot sequencer and saturating voice mixer
module multi_sample_player
    import multi_sample_player_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int DIV      = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          trig,
    input  logic [CHANNELS-1:0]          stop,
    input  logic [CHANNELS-1:0]          loop,
    input  logic [CHANNELS*ADDR_W-1:0]   start_addr,
    input  logic [CHANNELS*ADDR_W-1:0]   length,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [7:0]                   rom_data,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          done,
    output logic signed [15:0]           audio,
    output logic                         sample_strobe
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]           count;
    logic                       primed;
    logic                       tick;
    logic                       mix_load;
    logic [ADDR_W-1:0]          fetch_addr [CHANNELS];
    logic signed [SAMPLE_W-1:0] sample     [CHANNELS];
    logic [ADDR_W-1:0]          rom_addr_n;
    logic signed [MIX_W-1:0]    mix;

    // primed holds off the first tick so a reset always gives one full idle period
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            primed <= 1'b0;
        end else if (count == CNT_W'(DIV - 1)) begin
            count  <= '0;
            primed <= 1'b1;
        end else begin
            count  <= count + CNT_W'(1);
        end
    end

    assign tick     = primed && (count == '0);
    assign mix_load = primed && (count == CNT_W'(2 * CHANNELS + 1));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
        sample_voice #(.ADDR_W(ADDR_W)) u_voice (
            .clk        (clk),
            .reset      (reset),
            .trig       (trig[i]),
            .stop       (stop[i]),
            .loop       (loop[i]),
            .start_in   (start_addr[i*ADDR_W +: ADDR_W]),
            .length_in  (length[i*ADDR_W +: ADDR_W]),
            .tick       (tick),
            .capture    (primed && (count == CNT_W'(2 * i + 2))),
            .rom_data   (rom_data),
            .fetch_addr (fetch_addr[i]),
            .busy       (busy[i]),
            .done       (done[i]),
            .sample     (sample[i])
        );
    end

    always_comb begin
        rom_addr_n = rom_addr;
        for (int i = 0; i < CHANNELS; i++) begin
            if (primed && count == CNT_W'(2 * i)) begin
                rom_addr_n = fetch_addr[i];
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix = mix + ({{(MIX_W-SAMPLE_W){sample[i][SAMPLE_W-1]}}, sample[i]} << 8);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr      <= '0;
            audio         <= '0;
            sample_strobe <= 1'b0;
        end else begin
            rom_addr      <= rom_addr_n;
            sample_strobe <= mix_load;
            if (mix_load) begin
                audio <= saturate(mix);
            end
        end
    end

endmodule

// File: tb/tb_multi_sample_player.sv
// tb/tb_multi_sample_player.sv - scoreboard bench with a per-period voice model and random traffic
module tb_multi_sample_player;

    localparam int CH = 4;
    localparam int DV = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [CH-1:0]      trig = '0, stop = '0, loop = '0;
    logic [CH*16-1:0]   start_addr = '0, length = '0;
    logic [15:0]        rom_addr;
    logic [7:0]         rom_data = '0;
    logic [CH-1:0]      busy, done;
    logic signed [15:0] audio;
    logic               sample_strobe;

    multi_sample_player #(.CHANNELS(CH), .ADDR_W(16), .DIV(DV)) dut (
        .clk(clk), .reset(reset), .trig(trig), .stop(stop), .loop(loop),
        .start_addr(start_addr), .length(length), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .done(done), .audio(audio),
        .sample_strobe(sample_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_addr[7:0];

    typedef struct {
        logic signed [15:0]   audio;
        logic [CH-1:0]        busy;
        logic [CH-1:0]        dn;
        logic [CH-1:0]        chk;
        logic [CH-1:0][15:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hist[$];
    int          dcnt[CH];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;

    logic [CH-1:0] ptg = '0, pst = '0, m_act = '0;
    logic [15:0]   m_start[CH];
    int            m_len[CH];
    int            m_pos[CH];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, k);
        end
    endtask

    // One period of playback evaluated from the rules, applied at each tick
    task automatic model_tick();
        exp_t        e;
        longint      sum = 0;
        logic [15:0] a;
        for (int i = 0; i < CH; i++) begin
            if (pst[i]) m_act[i] = 1'b0;
            else if (ptg[i] && length[i*16 +: 16] != 0) begin
                m_act[i]   = 1'b1;
                m_start[i] = start_addr[i*16 +: 16];
                m_len[i]   = int'(length[i*16 +: 16]);
                m_pos[i]   = 0;
            end
        end
        ptg = '0;
        pst = '0;
        e.dn = '0;
        e.chk = '0;
        e.addr = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_act[i]) begin
                a = m_start[i] + 16'(m_pos[i]);
                e.addr[i] = a;
                e.chk[i] = 1'b1;
                sum += (longint'(a[7:0]) - 128) * 256;
                m_pos[i]++;
                if (m_pos[i] == m_len[i]) begin
                    m_pos[i] = 0;
                    if (!loop[i]) begin
                        m_act[i] = 1'b0;
                        e.dn[i] = 1'b1;
                    end
                end
            end
        end
        e.audio = (sum > 32767) ? 16'sd32767 : (sum < -32768) ? -16'sd32768 : 16'(sum);
        e.busy = m_act;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(negedge clk);
        k++;
        check("strobe_timing", longint'(sample_strobe), longint'(k >= DV && k % DV == 2*CH+2));
        if (k >= DV && k % DV == 0) model_tick();
    endtask

    task automatic run_period(input logic [CH-1:0] tg, input logic [CH-1:0] sp,
                              input logic [CH-1:0] lp, input logic [CH*16-1:0] sa,
                              input logic [CH*16-1:0] ln);
        int w;
        while (k % DV != DV - 5) cycle();
        cycle();
        loop = lp;
        start_addr = sa;
        length = ln;
        trig = tg;
        stop = sp;
        ptg |= tg;
        pst |= sp;
        w = $urandom_range(1, 3);
        repeat (w) cycle();
        trig = '0;
        stop = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        trig = '0;
        stop = '0;
        exp_q.delete();
        ptg = '0;
        pst = '0;
        m_act = '0;
        for (int i = 0; i < CH; i++) begin
            m_start[i] = '0;
            m_len[i] = 0;
            m_pos[i] = 0;
        end
        repeat (n) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_audio", longint'(audio), 0);
        check("rst_rom_addr", longint'(rom_addr), 0);
        check("rst_strobe", longint'(sample_strobe), 0);
        reset = 1'b0;
        k = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < CH; i++) dcnt[i] = 0;
        end else begin
            exp_t e;
            int   idx;
            hist.push_back(rom_addr);
            if (hist.size() > 32) void'(hist.pop_front());
            for (int i = 0; i < CH; i++) if (done[i]) dcnt[i]++;
            if (sample_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", k);
                end else begin
                    e = exp_q.pop_front();
                    check("audio", longint'(audio), longint'(e.audio));
                    check("busy", longint'(busy), longint'(e.busy));
                    for (int i = 0; i < CH; i++) begin
                        check($sformatf("done_count[%0d]", i), dcnt[i], longint'(e.dn[i]));
                        idx = hist.size() - 1 - (2*CH + 1 - 2*i);
                        if (e.chk[i] && idx >= 0)
                            check($sformatf("rom_addr[%0d]", i), longint'(hist[idx]), longint'(e.addr[i]));
                    end
                end
                for (int i = 0; i < CH; i++) dcnt[i] = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CH-1:0]    rt, rs, rl;
        logic [CH*16-1:0] sa, ln;
        do_reset(3);

        // single shot on ch0
        run_period(4'b0001, '0, '0, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0003);
        repeat (4) run_period('0, '0, '0, 64'h1111_2222_3333_4444, 64'h0009_0009_0009_0009);

        // looping ch1, length 2
        run_period(4'b0010, '0, 4'b0010, 64'h0000_0000_0400_0000, 64'h0000_0000_0002_0000);
        repeat (5) run_period('0, '0, 4'b0010, 64'h0000_0000_0500_0000, '0);
        run_period('0, 4'b0010, 4'b0010, '0, '0);

        // saturation: all 0xFF, all 0x00, then 0xFF against 0x00
        run_period(4'b1111, '0, 4'b1111, {4{16'h01FF}}, {4{16'd1}});
        run_period('0, '0, 4'b1111, '0, '0);
        run_period(4'b1111, '0, 4'b1111, {4{16'h0200}}, {4{16'd1}});
        run_period('0, '0, 4'b1111, '0, '0);
        run_period(4'b0011, 4'b1100, 4'b1111, 64'h0000_0000_0200_01FF, {4{16'd1}});
        run_period('0, '0, 4'b0011, '0, '0);
        run_period('0, 4'b0011, 4'b0000, '0, '0);

        // stop wins over trig; zero length ignored whether idle or busy
        run_period(4'b0100, 4'b0100, '0, 64'h0000_0600_0000_0000, 64'h0000_0005_0000_0000);
        run_period(4'b0100, '0, '0, 64'h0000_0600_0000_0000, '0);
        run_period(4'b0001, '0, '0, 64'h0000_0000_0000_0700, 64'h0000_0000_0000_0004);
        run_period(4'b0001, '0, '0, 64'h0000_0000_0000_0800, '0);
        repeat (4) run_period('0, '0, '0, '0, '0);

        // retrigger ch3 at ptr 5, with start_addr moved after the tick in between
        run_period(4'b1000, '0, '0, 64'h0900_0000_0000_0000, 64'h000A_0000_0000_0000);
        repeat (4) run_period('0, '0, '0, 64'h0A00_0000_0000_0000, 64'h0003_0000_0000_0000);
        run_period(4'b1000, '0, '0, 64'h0B00_0000_0000_0000, 64'h0004_0000_0000_0000);
        repeat (5) run_period('0, '0, '0, 64'h0C00_0000_0000_0000, '0);

        // random traffic, including address wrap at 0xFFFF
        repeat (80) begin
            rt = CH'($urandom);
            rl = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                rs[i] = ($urandom_range(0, 5) == 0);
                sa[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                ln[i*16 +: 16] = 16'($urandom_range(0, 5));
            end
            run_period(rt, rs, rl, sa, ln);
        end

        // reset three cycles into a fetch sequence
        while (k % DV != 2) cycle();
        cycle();
        do_reset(3);
        run_period(4'b0101, '0, 4'b0101, 64'h0000_0D00_0000_0E00, 64'h0000_0003_0000_0002);
        repeat (3) run_period('0, 4'b0101, '0, '0, '0);
        while (k % DV != DV - 5) cycle();

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
